// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access pipeline stage.
//   - StoreSrc / LoadSrc access-size encodings
//   - ResultSrc code that marks a load
//   - FSM state encoding and the bus-timeout limit
//   - is_misaligned(): alignment rule shared by the stage
package mem_pkg;

  typedef enum logic [1:0] {
    StoreWord = 2'b00,
    StoreHalf = 2'b01,
    StoreByte = 2'b10
  } store_src_e;

  typedef enum logic [2:0] {
    LoadWord  = 3'b000,
    LoadHalf  = 3'b001,
    LoadHalfU = 3'b010,
    LoadByte  = 3'b011,
    LoadByteU = 3'b100
  } load_src_e;

  localparam logic [2:0] RESULT_SRC_LOAD = 3'b001;

  typedef enum logic {
    StIdle,
    StWait
  } mem_state_e;

  localparam int unsigned TIMEOUT_MAX = 255;

  // Bytes never misalign; halves need addr[0]=0, words need addr[1:0]=0.
  function automatic logic is_misaligned(logic is_half, logic is_word, logic [1:0] addr_lo);
    return (is_half && addr_lo[0]) || (is_word && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the memory-access stage and the data memory.
//   master : stage side  (drives req/we/addr/be/wdata, receives ready/rdata)
//   slave  : memory side (the reverse)
interface mem_access_stage_if;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_be,
    output dmem_wdata,
    input  dmem_ready,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_be,
    input  dmem_wdata,
    output dmem_ready,
    output dmem_rdata
  );

endinterface

// File: rtl/load_store_align.sv
// Combinational lane steering for the memory-access stage.
// Ports:
//   addr_lo    in  2   byte offset within the word
//   is_store   in  1   current op is a store (byte enables are zero otherwise)
//   store_src  in  2   store size encoding
//   load_src   in  3   load size / signedness encoding
//   store_data in  32  raw store data
//   rdata      in  32  raw word read from memory
//   be         out 4   byte enables
//   wdata      out 32  store data replicated across lanes
//   load_data  out 32  selected lane, sign- or zero-extended
module load_store_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [1:0]  store_src,
  input  logic [2:0]  load_src,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] lane;

  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    case (store_src)
      StoreHalf: begin
        wdata = {2{store_data[15:0]}};
        be    = 4'b0011 << addr_lo;
      end
      StoreByte: begin
        wdata = {4{store_data[7:0]}};
        be    = 4'b0001 << addr_lo;
      end
      default: begin
        wdata = store_data;
        be    = 4'b1111;
      end
    endcase
    if (!is_store) begin
      be = 4'b0000;
    end
  end

  // Shift the addressed lane down to bit 0 before extension.
  always_comb begin
    lane      = rdata >> {addr_lo, 3'b000};
    load_data = lane;
    case (load_src)
      LoadHalf:  load_data = {{16{lane[15]}}, lane[15:0]};
      LoadHalfU: load_data = {16'h0000, lane[15:0]};
      LoadByte:  load_data = {{24{lane[7]}}, lane[7:0]};
      LoadByteU: load_data = {24'h000000, lane[7:0]};
      default:   load_data = lane;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: E/M pipeline register, data-memory request FSM,
// alignment checking and load/store lane formatting.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   RegWriteE..LoadSrcE        execute-stage controls and data captured into E/M
//   FlushM                     load a bubble into E/M (ignored while stalled)
//   RegWriteM..PCPlus4M        registered stage outputs (RegWriteM gated by faults)
//   ReadDataM                  extended load data, valid while dmem_ready=1
//   StallMem                   freezes upstream stages while an access is pending
//   MisalignM                  misaligned memory op (never issued to memory)
//   BusErrM                    one-cycle pulse on bus timeout (only with MEM_TIMEOUT_EN)
//   dmem                       data-memory bus (master side)
// Build option: define MEM_TIMEOUT_EN to bound the WAIT state by TIMEOUT_MAX cycles.
module mem_access_stage
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWriteE,
  input  logic        MemWriteE,
  input  logic [2:0]  ResultSrcE,
  input  logic [4:0]  RdE,
  input  logic [31:0] ALUResultE,
  input  logic [31:0] WriteDataE,
  input  logic [31:0] PCPlus4E,
  input  logic [1:0]  StoreSrcE,
  input  logic [2:0]  LoadSrcE,
  input  logic        FlushM,
  output logic        RegWriteM,
  output logic [2:0]  ResultSrcM,
  output logic [4:0]  RdM,
  output logic [31:0] ALUResultM,
  output logic [31:0] PCPlus4M,
  output logic [31:0] ReadDataM,
  output logic        StallMem,
  output logic        MisalignM,
`ifdef MEM_TIMEOUT_EN
  output logic        BusErrM,
`endif
  mem_access_stage_if.master dmem
);

  // E/M pipeline register
  logic        reg_write_q;
  logic        mem_write_q;
  logic [2:0]  result_src_q;
  logic [4:0]  rd_q;
  logic [31:0] alu_result_q;
  logic [31:0] write_data_q;
  logic [31:0] pc_plus4_q;
  logic [1:0]  store_src_q;
  logic [2:0]  load_src_q;

  mem_state_e  state_q;
  logic        timeout;

  logic        is_load;
  logic        is_store;
  logic        mem_op;
  logic        is_half;
  logic        is_byte;
  logic        is_word;
  logic        misalign;
  logic        access_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= 3'b000;
      rd_q         <= 5'd0;
      alu_result_q <= 32'h0;
      write_data_q <= 32'h0;
      pc_plus4_q   <= 32'h0;
      store_src_q  <= 2'b00;
      load_src_q   <= 3'b000;
    end else if (!StallMem) begin
      reg_write_q  <= FlushM ? 1'b0 : RegWriteE;
      mem_write_q  <= FlushM ? 1'b0 : MemWriteE;
      result_src_q <= FlushM ? 3'b000 : ResultSrcE;
      rd_q         <= RdE;
      alu_result_q <= ALUResultE;
      write_data_q <= WriteDataE;
      pc_plus4_q   <= PCPlus4E;
      store_src_q  <= StoreSrcE;
      load_src_q   <= LoadSrcE;
    end
  end

  // Access classification. A store takes its size from StoreSrc, a load from LoadSrc;
  // unknown encodings fall back to word.
  always_comb begin
    is_store = mem_write_q;
    is_load  = (result_src_q == RESULT_SRC_LOAD);
    mem_op   = is_store || is_load;
    if (is_store) begin
      is_half = (store_src_q == StoreHalf);
      is_byte = (store_src_q == StoreByte);
    end else begin
      is_half = (load_src_q == LoadHalf) || (load_src_q == LoadHalfU);
      is_byte = (load_src_q == LoadByte) || (load_src_q == LoadByteU);
    end
    is_word   = !is_half && !is_byte;
    misalign  = mem_op && is_misaligned(is_half, is_word, alu_result_q[1:0]);
    access_ok = mem_op && !misalign;
  end

`ifdef MEM_TIMEOUT_EN
  logic [7:0] tmo_cnt_q;

  assign timeout = (state_q == StWait) && (tmo_cnt_q == 8'(TIMEOUT_MAX)) && !dmem.dmem_ready;
  assign BusErrM = timeout;
`else
  assign timeout = 1'b0;
`endif

  // The request is decoded from the registered op, so it is stable for the whole
  // access: the E/M register holds while StallMem=1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt_q <= 8'd0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (access_ok && !dmem.dmem_ready) begin
            state_q <= StWait;
          end
`ifdef MEM_TIMEOUT_EN
          tmo_cnt_q <= 8'd0;
`endif
        end
        StWait: begin
          if (dmem.dmem_ready || timeout) begin
            state_q <= StIdle;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt_q <= 8'd0;
`endif
          end else begin
`ifdef MEM_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign dmem.dmem_req  = (state_q == StWait) || access_ok;
  assign dmem.dmem_we   = dmem.dmem_req && mem_write_q;
  assign dmem.dmem_addr = {alu_result_q[31:2], 2'b00};

  assign StallMem  = dmem.dmem_req && !dmem.dmem_ready && !timeout;
  assign MisalignM = misalign;

  assign RegWriteM  = reg_write_q && !misalign && !timeout;
  assign ResultSrcM = result_src_q;
  assign RdM        = rd_q;
  assign ALUResultM = alu_result_q;
  assign PCPlus4M   = pc_plus4_q;

  load_store_align u_align (
    .addr_lo    (alu_result_q[1:0]),
    .is_store   (is_store),
    .store_src  (store_src_q),
    .load_src   (load_src_q),
    .store_data (write_data_q),
    .rdata      (dmem.dmem_rdata),
    .be         (dmem.dmem_be),
    .wdata      (dmem.dmem_wdata),
    .load_data  (ReadDataM)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases followed by random
// load/store/ALU traffic with random memory latency, checked against a size/offset
// arithmetic model of the access rules.
module tb_mem_access_stage;

  logic        clk;
  logic        rst_n;
  logic        RegWriteE;
  logic        MemWriteE;
  logic [2:0]  ResultSrcE;
  logic [4:0]  RdE;
  logic [31:0] ALUResultE;
  logic [31:0] WriteDataE;
  logic [31:0] PCPlus4E;
  logic [1:0]  StoreSrcE;
  logic [2:0]  LoadSrcE;
  logic        FlushM;
  logic        RegWriteM;
  logic [2:0]  ResultSrcM;
  logic [4:0]  RdM;
  logic [31:0] ALUResultM;
  logic [31:0] PCPlus4M;
  logic [31:0] ReadDataM;
  logic        StallMem;
  logic        MisalignM;
`ifdef MEM_TIMEOUT_EN
  logic        BusErrM;
`endif

  mem_access_stage_if dmem_bus ();

  mem_access_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RegWriteE  (RegWriteE),
    .MemWriteE  (MemWriteE),
    .ResultSrcE (ResultSrcE),
    .RdE        (RdE),
    .ALUResultE (ALUResultE),
    .WriteDataE (WriteDataE),
    .PCPlus4E   (PCPlus4E),
    .StoreSrcE  (StoreSrcE),
    .LoadSrcE   (LoadSrcE),
    .FlushM     (FlushM),
    .RegWriteM  (RegWriteM),
    .ResultSrcM (ResultSrcM),
    .RdM        (RdM),
    .ALUResultM (ALUResultM),
    .PCPlus4M   (PCPlus4M),
    .ReadDataM  (ReadDataM),
    .StallMem   (StallMem),
    .MisalignM  (MisalignM),
`ifdef MEM_TIMEOUT_EN
    .BusErrM    (BusErrM),
`endif
    .dmem       (dmem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned acc_size(bit mw, logic [1:0] ss, logic [2:0] ls);
    if (mw) return (ss == 2'd0) ? 4 : (ss == 2'd1) ? 2 : 1;
    return (ls == 3'd0) ? 4 : (ls <= 3'd2) ? 2 : 1;
  endfunction

  function automatic logic [3:0] be_model(bit mw, logic [1:0] ss, logic [31:0] addr);
    int unsigned sz = acc_size(mw, ss, 3'd0);
    if (!mw) return 4'd0;
    if (sz == 4) return 4'hF;
    return 4'(((1 << sz) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] wdata_model(logic [1:0] ss, logic [31:0] wd);
    longint unsigned w = wd;
    case (acc_size(1'b1, ss, 3'd0))
      2:       return 32'((w % 65536) * 65537);
      1:       return 32'((w % 256) * 32'h01010101);
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_model(logic [2:0] ls, logic [31:0] addr,
                                             logic [31:0] rdata);
    longint unsigned sz  = acc_size(1'b0, 2'd0, ls);
    longint unsigned r   = rdata;
    longint unsigned v   = (r >> (8 * (addr % 4))) % (64'd1 << (8 * sz));
    bit              sgn = (ls == 3'd0) || (ls == 3'd1) || (ls == 3'd3);
    if (sgn && (v >= (64'd1 << (8 * sz - 1)))) v = v - (64'd1 << (8 * sz));
    return 32'(v);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive_e(input bit rw, input bit mw, input logic [2:0] rs, input logic [4:0] rd,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] pc,
                         input logic [1:0] ss, input logic [2:0] ls);
    RegWriteE  = rw;
    MemWriteE  = mw;
    ResultSrcE = rs;
    RdE        = rd;
    ALUResultE = addr;
    WriteDataE = wd;
    PCPlus4E   = pc;
    StoreSrcE  = ss;
    LoadSrcE   = ls;
  endtask

  task automatic drive_bubble();
    drive_e(1'b0, 1'b0, 3'b000, 5'($urandom), $urandom, $urandom, $urandom, 2'd0, 3'd0);
  endtask

  // Issue one instruction, let the memory answer after lat cycles, check every cycle.
  task automatic run_op(input string nm, input bit rw, input bit mw, input logic [2:0] rs,
                        input logic [1:0] ss, input logic [2:0] ls, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rdata, input int lat,
                        input bit flush_in_stall);
    logic [4:0]  rd = 5'($urandom);
    logic [31:0] pc = $urandom;
    bit          mop = mw || (rs == 3'b001);
    bit          mis = mop && ((addr % acc_size(mw, ss, ls)) != 0);
    int          n = (mop && !mis) ? lat : 0;
    FlushM = 1'b0;
    drive_e(rw, mw, rs, rd, addr, wd, pc, ss, ls);
    tick();
    drive_bubble();
    for (int c = 0; c <= n; c++) begin
      dmem_bus.dmem_ready = (c == n);
      dmem_bus.dmem_rdata = rdata;
      FlushM              = (c < n) ? flush_in_stall : 1'b0;
      #2;
      chk({nm, ":misalign"}, 32'(MisalignM), 32'(mis));
      chk({nm, ":req"}, 32'(dmem_bus.dmem_req), 32'(mop && !mis));
      chk({nm, ":stall"}, 32'(StallMem), 32'(c < n));
      chk({nm, ":regwrite"}, 32'(RegWriteM), 32'(rw && !mis));
      chk({nm, ":ressrc"}, 32'(ResultSrcM), 32'(rs));
      chk({nm, ":pc_hold"}, PCPlus4M, pc);
      chk({nm, ":rd_hold"}, 32'(RdM), 32'(rd));
      chk({nm, ":alu_hold"}, ALUResultM, addr);
      if (mop && !mis) begin
        chk({nm, ":addr"}, dmem_bus.dmem_addr, addr & 32'hFFFF_FFFC);
        chk({nm, ":we"}, 32'(dmem_bus.dmem_we), 32'(mw));
        chk({nm, ":be"}, 32'(dmem_bus.dmem_be), 32'(be_model(mw, ss, addr)));
        if (mw) chk({nm, ":wdata"}, dmem_bus.dmem_wdata, wdata_model(ss, wd));
        if (!mw && c == n) chk({nm, ":rdata"}, ReadDataM, load_model(ls, addr, rdata));
      end
      tick();
    end
    dmem_bus.dmem_ready = 1'b0;
    FlushM              = 1'b0;
    #2;
    chk({nm, ":req_drop"}, 32'(dmem_bus.dmem_req), 32'd0);
    chk({nm, ":stall_drop"}, 32'(StallMem), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n               = 1'b0;
    FlushM              = 1'b0;
    dmem_bus.dmem_ready = 1'b0;
    dmem_bus.dmem_rdata = 32'h0;
    drive_e(1'b1, 1'b1, 3'b001, 5'd7, 32'h1234_5678, 32'hFFFF_FFFF, 32'h40, 2'd1, 3'd1);
    tick();
    tick();
    #2;
    chk("rst:regwrite", 32'(RegWriteM), 32'd0);
    chk("rst:ressrc", 32'(ResultSrcM), 32'd0);
    chk("rst:rd", 32'(RdM), 32'd0);
    chk("rst:alu", ALUResultM, 32'd0);
    chk("rst:pc", PCPlus4M, 32'd0);
    chk("rst:req", 32'(dmem_bus.dmem_req), 32'd0);
    chk("rst:stall", 32'(StallMem), 32'd0);
    chk("rst:misalign", 32'(MisalignM), 32'd0);
    rst_n = 1'b1;
    drive_bubble();
    tick();

    run_op("sw104", 1'b0, 1'b1, 3'b000, 2'd0, 3'd0, 32'h104, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
    run_op("lb103", 1'b1, 1'b0, 3'b001, 2'd0, 3'd3, 32'h103, 32'h0, 32'h80FF_0000, 0, 1'b0);
    run_op("lbu103", 1'b1, 1'b0, 3'b001, 2'd0, 3'd4, 32'h103, 32'h0, 32'h80FF_0000, 0, 1'b0);
    run_op("lhu102", 1'b1, 1'b0, 3'b001, 2'd0, 3'd2, 32'h102, 32'h0, 32'h80FF_0000, 0, 1'b0);
    run_op("lh102", 1'b1, 1'b0, 3'b001, 2'd0, 3'd1, 32'h102, 32'h0, 32'h80FF_0000, 1, 1'b0);
    run_op("sh101", 1'b1, 1'b1, 3'b000, 2'd1, 3'd0, 32'h101, 32'hCAFE_1234, 32'h0, 0, 1'b0);
    run_op("lw102", 1'b1, 1'b0, 3'b001, 2'd0, 3'd0, 32'h102, 32'h0, 32'h1111_2222, 0, 1'b0);
    run_op("lw_lat3", 1'b1, 1'b0, 3'b001, 2'd0, 3'd0, 32'h200, 32'h0, 32'hA5A5_5A5A, 3, 1'b0);
    run_op("sb_lat2", 1'b0, 1'b1, 3'b000, 2'd2, 3'd0, 32'h303, 32'h0000_00C3, 32'h0, 2, 1'b0);
    run_op("sh_lat1", 1'b0, 1'b1, 3'b000, 2'd1, 3'd0, 32'h306, 32'h0000_BEEF, 32'h0, 1, 1'b0);
    run_op("flush_ign", 1'b1, 1'b0, 3'b001, 2'd0, 3'd3, 32'h401, 32'h0, 32'h0000_7F00, 2, 1'b1);
    run_op("alu", 1'b1, 1'b0, 3'b000, 2'd0, 3'd0, 32'h123, 32'h0, 32'h0, 2, 1'b0);

    // Flush with no stall turns a memory op into a bubble.
    drive_e(1'b1, 1'b1, 3'b001, 5'd3, 32'h500, 32'h1, 32'h8, 2'd0, 3'd0);
    FlushM = 1'b1;
    tick();
    FlushM = 1'b0;
    drive_bubble();
    #2;
    chk("flush:regwrite", 32'(RegWriteM), 32'd0);
    chk("flush:ressrc", 32'(ResultSrcM), 32'd0);
    chk("flush:req", 32'(dmem_bus.dmem_req), 32'd0);
    tick();

    // Reset during WAIT abandons the access.
    drive_e(1'b1, 1'b0, 3'b001, 5'd9, 32'h600, 32'h0, 32'h20, 2'd0, 3'd0);
    tick();
    drive_bubble();
    tick();
    #2;
    chk("rstwait:stall_before", 32'(StallMem), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #2;
    chk("rstwait:req", 32'(dmem_bus.dmem_req), 32'd0);
    chk("rstwait:stall", 32'(StallMem), 32'd0);
    chk("rstwait:misalign", 32'(MisalignM), 32'd0);
    chk("rstwait:rd", 32'(RdM), 32'd0);
    tick();

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      int          kind = $urandom_range(0, 8);
      logic [31:0] a    = 32'h1000 + $urandom_range(0, 63);
      logic [31:0] w    = $urandom;
      logic [31:0] r    = $urandom;
      int          lat  = $urandom_range(0, 3);
      bit          fl   = 1'($urandom);
      if (kind == 0)
        run_op("rnd_alu", 1'b1, 1'b0, 3'b010, 2'd0, 3'd0, a, w, r, lat, fl);
      else if (kind <= 3)
        run_op("rnd_st", 1'b0, 1'b1, 3'b000, 2'(kind - 1), 3'd0, a, w, r, lat, fl);
      else
        run_op("rnd_ld", 1'b1, 1'b0, 3'b001, 2'd0, 3'(kind - 4), a, w, r, lat, fl);
      tick();
    end

`ifdef MEM_TIMEOUT_EN
    begin
      int stalls = 0;
      bit seen   = 1'b0;
      drive_e(1'b1, 1'b0, 3'b001, 5'd4, 32'h700, 32'h0, 32'h30, 2'd0, 3'd0);
      tick();
      drive_bubble();
      dmem_bus.dmem_ready = 1'b0;
      for (int c = 0; c < 400; c++) begin
        #2;
        if (BusErrM) begin
          seen = 1'b1;
          chk("tmo:regwrite", 32'(RegWriteM), 32'd0);
          chk("tmo:stall", 32'(StallMem), 32'd0);
          tick();
          break;
        end
        if (StallMem) stalls++;
        tick();
      end
      #2;
      chk("tmo:seen", 32'(seen), 32'd1);
      chk("tmo:stall_cycles", 32'(stalls), 32'd256);
      chk("tmo:pulse_end", 32'(BusErrM), 32'd0);
      chk("tmo:req_drop", 32'(dmem_bus.dmem_req), 32'd0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
- REQ-001: The block SHALL have one clock and synchronous active-low reset: clk input 1 (rising-edge clock); rst_n input 1 (synchronous reset, active low).
- REQ-002: RegWriteE, MemWriteE input 1; ResultSrcE input 3 (3'b001 = load); RdE input 5; all are execute-stage controls.
- REQ-003: ALUResultE input 32 (address or ALU result); WriteDataE input 32 (store data); PCPlus4E input 32.
- REQ-004: StoreSrcE input 2 (00 word, 01 half, 10 byte); LoadSrcE input 3 (000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu).
- REQ-005: FlushM input 1 loads a bubble into the E/M register.
- REQ-006: RegWriteM output 1; ResultSrcM output 3; RdM output 5; ALUResultM output 32; PCPlus4M output 32; these are registered stage outputs.
- REQ-007: ReadDataM output 32 carries the extended load data; StallMem output 1 freezes upstream stages; MisalignM output 1 flags a misaligned access.
- REQ-008: Data-memory port: dmem_req output 1; dmem_we output 1; dmem_addr output 32 (word-aligned); dmem_be output 4; dmem_wdata output 32; dmem_ready input 1; dmem_rdata input 32.

Function
- REQ-009: The E/M register SHALL capture all E inputs on a rising edge when StallMem=0; when StallMem=1 it SHALL hold.
- REQ-010: FlushM=1 with StallMem=0 SHALL load zeros into RegWrite, MemWrite and ResultSrc, making a bubble; FlushM SHALL be ignored while StallMem=1.
- REQ-011: An instruction is a memory op when MemWriteM=1 or ResultSrcM=3'b001.
- REQ-012: An access is misaligned when it is a half access with addr[0]=1, or a word access with addr[1:0]!=0. Misaligned memory ops SHALL assert MisalignM, SHALL never assert dmem_req, and SHALL force RegWriteM=0.
- REQ-013: Address and data formatting: dmem_addr = {ALUResultM[31:2],2'b00}.
  - Stores SHALL replicate the byte or half across lanes in dmem_wdata.
  - dmem_be = 1111 for a word, 0011<<addr[1:0] for a half, 0001<<addr[1:0] for a byte.
  - dmem_be SHALL be 0000 for loads.
- REQ-014: Loads SHALL select the lane from dmem_rdata using addr[1:0], then sign- or zero-extend per LoadSrcM. ReadDataM is valid in the cycle dmem_ready=1.
- REQ-015: FSM state IDLE: an aligned memory op drives dmem_req=1 and dmem_we=MemWriteM.
  - dmem_ready=1 in the same cycle: completes in 0 extra cycles; stays IDLE; StallMem=0.
  - dmem_ready=0: StallMem=1; next state WAIT.
- REQ-016: FSM state WAIT: dmem_req, addr, be and wdata SHALL hold stable; StallMem=1 until dmem_ready=1. On ready: StallMem=0; next state IDLE.
- REQ-017: Non-memory instructions SHALL pass with dmem_req=0 and StallMem=0.
- REQ-018: dmem_req SHALL deassert in the cycle after the accepting dmem_ready, unless a new memory op has been captured.

Reset
- REQ-019: rst_n=0 sampled at a rising edge SHALL clear every E/M register field to 0 and set the FSM to IDLE.
- REQ-020: Asserting rst_n=0 mid-WAIT SHALL abandon the access: dmem_req=0, StallMem=0 and MisalignM=0 from the next cycle.

Configuration
- REQ-021: Macro MEM_TIMEOUT_EN.
  - When defined: an 8-bit counter increments in WAIT and clears on leaving WAIT.
  - On reaching 255 without dmem_ready, the FSM SHALL return to IDLE, pulse output BusErrM for 1 cycle, force RegWriteM=0 and drop StallMem.
  - When undefined: no counter, no BusErrM port, and WAIT is unbounded.

Structure
- REQ-022: Package mem_pkg SHALL hold the StoreSrc and LoadSrc encodings, the load ResultSrc code, the FSM state enum and TIMEOUT_MAX=255.
- REQ-023: A combinational sub-module load_store_align SHALL perform lane, byte-enable, replication and extension.

Verification
- REQ-024: sw addr 0x104, data 0xDEADBEEF, ready tied 1 -> dmem_be=1111, dmem_addr=0x104, no stall.
- REQ-025: lb addr 0x103, rdata 0x80FF_0000 -> ReadDataM=0xFFFFFF80; lbu -> 0x00000080; lhu addr 0x102 -> 0x000080FF.
- REQ-026: sh addr 0x101 -> MisalignM=1, dmem_req=0, RegWriteM=0.
- REQ-027: lw with ready delayed 3 cycles -> StallMem=1 for 3 cycles, req/addr stable, E/M register held, completion on the 4th cycle.
- REQ-028: rst_n=0 during WAIT -> IDLE next cycle, req=0; with MEM_TIMEOUT_EN and ready never asserted -> BusErrM pulses after 255 WAIT cycles.
